// File: rtl/icache_assoc_if.sv
// Memory-side bus of the instruction cache.
//   master (cache)  : drives mem_req_valid / mem_req_addr, receives ready and fill beats
//   slave  (memory) : accepts line requests, returns BEATS fill beats in ascending address order
interface icache_assoc_if #(
   parameter int ADDRWIDTH = 64,
   parameter int BUSWIDTH  = 64
);
   logic                 mem_req_valid;
   logic [ADDRWIDTH-1:0] mem_req_addr;
   logic                 mem_req_ready;
   logic                 mem_resp_valid;
   logic [BUSWIDTH-1:0]  mem_resp_data;

   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways) with per-set LRU, burst line
// fill, whole-cache flush and wrapping hit/miss counters.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   fetch request handshake, i_pc = fetch address
//   resp_valid            one-cycle pulse; out_instr / o_pc valid with it
//   flush                 pulse: invalidate all lines (applied in IDLE)
//   mem_bus               line request / fill beat bus (master side)
//   hit_count/miss_count  lookup counters
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a request; applies a pending flush
// S_LOOKUP   | tag compare on latched pc; hit -> S_RESP, miss -> S_MISS_REQ
// S_MISS_REQ | line request held on mem_bus until accepted
// S_FILL     | writing fill beats into the victim way, then replay lookup
// S_RESP     | resp_valid asserted for one cycle
module icache_assoc #(
   parameter int ADDRWIDTH = 64,
   parameter int INSTSIZE  = 32,
   parameter int NUMSETS   = 64,
   parameter int WAYS      = 2,
   parameter int LINEBYTES = 64,
   parameter int BUSWIDTH  = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDRWIDTH-1:0] i_pc,
   output logic                 resp_valid,
   output logic [INSTSIZE-1:0]  out_instr,
   output logic [ADDRWIDTH-1:0] o_pc,
   input  logic                 flush,
   icache_assoc_if.master       mem_bus,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
);
   localparam int OFFW     = $clog2(LINEBYTES);
   localparam int IDXW     = $clog2(NUMSETS);
   localparam int TAGW     = ADDRWIDTH - OFFW - IDXW;
   localparam int WORDW    = OFFW - 2;
   localparam int LINEBITS = LINEBYTES * 8;
   localparam int BEATS    = LINEBITS / BUSWIDTH;
   localparam int BEATW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEATW-1:0] BEAT_LAST = BEATW'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_MISS_REQ, S_FILL, S_RESP
   } state_t;

   state_t state_q, state_d;

   logic [ADDRWIDTH-1:0]             pc_q, pc_d;
   logic                             victim_q, victim_d;
   logic [BEATW-1:0]                 beats_left_q, beats_left_d;
   logic                             flush_pend_q, flush_pend_d;
   logic [WAYS-1:0][NUMSETS-1:0]     valid_q, valid_d;
   logic [NUMSETS-1:0]               lru_q, lru_d;
   logic [31:0]                      hit_cnt_q, hit_cnt_d;
   logic [31:0]                      miss_cnt_q, miss_cnt_d;
   logic [INSTSIZE-1:0]              out_instr_q, out_instr_d;
   logic [ADDRWIDTH-1:0]             o_pc_q, o_pc_d;

   // line storage, not reset
   logic [LINEBITS-1:0] data_mem [WAYS][NUMSETS];
   logic [TAGW-1:0]     tag_mem  [WAYS][NUMSETS];

   logic [TAGW-1:0]   tag_s;
   logic [IDXW-1:0]   idx_s;
   logic [WORDW-1:0]  word_s;
   logic [WAYS-1:0]   way_hit;
   logic              hit;
   logic              hit_way;
   logic              victim_c;
   logic [BEATW-1:0]  beat_idx;
   logic              fill_we;
   logic              fill_last;
   logic [INSTSIZE-1:0] lookup_instr;

   assign tag_s  = pc_q[ADDRWIDTH-1 -: TAGW];
   assign idx_s  = pc_q[OFFW +: IDXW];
   assign word_s = pc_q[2 +: WORDW];

   always_comb begin
      way_hit = '0;
      for (int w = 0; w < WAYS; w++)
         way_hit[w] = valid_q[w][idx_s] && (tag_mem[w][idx_s] == tag_s);
   end

   assign hit          = |way_hit;
   assign hit_way      = (WAYS > 1) ? ~way_hit[0] : 1'b0;
   assign lookup_instr = data_mem[hit_way][idx_s][word_s*INSTSIZE +: INSTSIZE];

   // lowest invalid way first, otherwise the LRU way
   always_comb begin
      if (!valid_q[0][idx_s])
         victim_c = 1'b0;
      else if (!valid_q[WAYS-1][idx_s])
         victim_c = 1'(WAYS - 1);
      else
         victim_c = lru_q[idx_s];
   end

   // beats_left counts down; beat position is its distance from the load value
   assign beat_idx  = BEAT_LAST - beats_left_q;
   assign fill_we   = (state_q == S_FILL) && mem_bus.mem_resp_valid;
   assign fill_last = fill_we && (beats_left_q == '0);

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (req_valid && req_ready) state_d = S_LOOKUP;
         S_LOOKUP:   state_d = hit ? S_RESP : S_MISS_REQ;
         S_MISS_REQ: if (mem_bus.mem_req_ready) state_d = S_FILL;
         S_FILL:     if (fill_last) state_d = S_LOOKUP;
         S_RESP:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready             = 1'b0;
      resp_valid            = 1'b0;
      mem_bus.mem_req_valid = 1'b0;
      case (state_q)
         S_IDLE:     req_ready = !flush_pend_q && !flush;
         S_MISS_REQ: mem_bus.mem_req_valid = 1'b1;
         S_RESP:     resp_valid = 1'b1;
         default:    ;
      endcase
   end

   assign mem_bus.mem_req_addr = {pc_q[ADDRWIDTH-1:OFFW], {OFFW{1'b0}}};
   assign out_instr            = out_instr_q;
   assign o_pc                 = o_pc_q;
   assign hit_count            = hit_cnt_q;
   assign miss_count           = miss_cnt_q;

   always_comb begin
      pc_d         = pc_q;
      victim_d     = victim_q;
      beats_left_d = beats_left_q;
      flush_pend_d = flush_pend_q | flush;
      valid_d      = valid_q;
      lru_d        = lru_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      out_instr_d  = out_instr_q;
      o_pc_d       = o_pc_q;
      case (state_q)
         S_IDLE: begin
            if (flush_pend_q || flush) begin
               valid_d      = '0;
               lru_d        = '0;
               flush_pend_d = 1'b0;
            end else if (req_valid) begin
               pc_d = i_pc;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               out_instr_d   = lookup_instr;
               o_pc_d        = pc_q;
               hit_cnt_d     = hit_cnt_q + 32'd1;
               lru_d[idx_s]  = ~hit_way;
            end else begin
               miss_cnt_d = miss_cnt_q + 32'd1;
               victim_d   = victim_c;
            end
         end
         S_MISS_REQ: begin
            if (mem_bus.mem_req_ready) beats_left_d = BEAT_LAST;
         end
         S_FILL: begin
            if (fill_we) begin
               if (beats_left_q == '0) begin
                  valid_d[victim_q][idx_s] = 1'b1;
                  lru_d[idx_s]             = ~victim_q;
               end else begin
                  beats_left_d = beats_left_q - BEATW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= '0;
         victim_q     <= 1'b0;
         beats_left_q <= '0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
         out_instr_q  <= '0;
         o_pc_q       <= '0;
      end else begin
         pc_q         <= pc_d;
         victim_q     <= victim_d;
         beats_left_q <= beats_left_d;
         flush_pend_q <= flush_pend_d;
         valid_q      <= valid_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         out_instr_q  <= out_instr_d;
         o_pc_q       <= o_pc_d;
      end
   end

   // a direct-mapped cache has nothing to remember about recency
   generate
      if (WAYS == 2) begin : g_lru
         always_ff @(posedge clk) begin
            if (reset)
               lru_q <= '0;
            else
               lru_q <= lru_d;
         end
      end else begin : g_no_lru
         assign lru_q = '0;
      end
   endgenerate

   // beats sampled on a reset edge are dropped
   always_ff @(posedge clk) begin
      if (fill_we && !reset)
         data_mem[victim_q][idx_s][beat_idx*BUSWIDTH +: BUSWIDTH] <= mem_bus.mem_resp_data;
      if (fill_last && !reset)
         tag_mem[victim_q][idx_s] <= tag_s;
   end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache between the fetch stage and the memory bus, the next generation of the single-line-lookup i_cache. Accepts one PC per request, returns the 32-bit instruction on a hit, and on a miss fetches the whole line as a multi-beat burst, fills a victim way chosen by per-set LRU, then replays the lookup. Adds a configurable way count, line size and bus width, a cache flush, and hit/miss counters.

## Interface
- ADDRWIDTH, 64, PC / bus address width
- INSTSIZE, 32, instruction width; fixed word size 4 bytes
- NUMSETS, 64, sets; power of two ≥ 2
- WAYS, 2, associativity; legal values 1 or 2
- LINEBYTES, 64, line size in bytes; power of two, multiple of BUSWIDTH/8
- BUSWIDTH, 64, memory data beat width
- Derived: OFFW = log2(LINEBYTES), IDXW = log2(NUMSETS), TAGW = ADDRWIDTH−OFFW−IDXW, BEATS = LINEBYTES*8/BUSWIDTH

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  fetch request
- req_ready  out  1  cache can accept a request
- i_pc  in  ADDRWIDTH  fetch address; bits [1:0] ignored
- resp_valid  out  1  one-cycle pulse, instruction valid
- out_instr  out  INSTSIZE  returned instruction
- o_pc  out  ADDRWIDTH  PC belonging to out_instr
- flush  in  1  invalidate every line
- mem_req_valid  out  1  line fill request
- mem_req_addr  out  ADDRWIDTH  line-aligned address (low OFFW bits zero)
- mem_req_ready  in  1  bus accepted request
- mem_resp_valid  in  1  fill beat valid
- mem_resp_data  in  BUSWIDTH  fill beat, ascending address order
- hit_count, miss_count  out  32  lookup counters, wrap on overflow

## Operation
- Address split: tag = pc[ADDRWIDTH−1:OFFW+IDXW], index = pc[OFFW+IDXW−1:OFFW], word = pc[OFFW−1:2].
- States: IDLE, LOOKUP, MISS_REQ, FILL, RESP.
- IDLE: req_ready = 1 unless a flush is pending. req_valid & req_ready latches i_pc -> LOOKUP.
- LOOKUP: hit = any way with valid & tag match. Hit: latch word into out_instr, update LRU to the other way, hit_count++ -> RESP. Miss: miss_count++, choose victim -> MISS_REQ.
- Victim: lowest-numbered invalid way; if none, the LRU way. WAYS = 1: always way 0, no LRU state.
- MISS_REQ: mem_req_valid = 1, address stable until mem_req_ready, then -> FILL.
- FILL: beat counter 0..BEATS−1; each mem_resp_valid writes a beat into the victim line. After the last beat, set valid and tag, set LRU to the non-victim way -> LOOKUP (replay hits; hit_count increments on replay, miss counted once).
- RESP: resp_valid = 1, out_instr/o_pc valid for this cycle only -> IDLE.
- Flush: a flush pulse in any state sets a pending flag; it is applied in IDLE (all valid and LRU bits cleared in one cycle). The flag blocks req_ready. A flush in IDLE coincident with req_valid wins; the request is not accepted.
- mem_resp_valid outside FILL is ignored.

## Timing
- Reset: state IDLE, all valid/LRU bits 0, flush pending 0, req_ready 1, resp_valid 0, out_instr 0, o_pc 0, mem_req_valid 0, mem_req_addr 0, counters 0. Data/tag arrays are not reset.
- Reset mid-fill: abandons the fill, and the line stays invalid. Beats still arriving after reset are ignored.
- Hit: request accepted in cycle N; resp_valid in N+2; req_ready high again in N+3. Throughput is one request every 3 cycles.
- Miss: mem_req_valid in N+2. With mem_req_ready = 1 immediately and back-to-back beats, the last beat arrives in N+3+BEATS−1, replay LOOKUP is in N+3+BEATS, and resp_valid is in N+4+BEATS.
- Fill gaps (mem_resp_valid low) stall the FILL state with no timeout.

## Test plan
- Reset, then request pc 0x1000 with a memory model returning beat k = {2k+1, 2k} words -> MISS_REQ with mem_req_addr 0x1000; resp at cycle 12 (BEATS = 8) with out_instr 0, o_pc 0x1000; miss_count 1, hit_count 1.
- Request pc 0x1004 after that fill -> resp_valid exactly 2 cycles after acceptance, out_instr 1, no mem_req_valid, hit_count 2.
- Fill pc 0x1000, 0x2000 and 0x3000 (all set 0, distinct tags), touching 0x2000 between the fills of 0x1000 and 0x3000 -> 0x3000 evicts the 0x1000 way. A re-request of 0x1000 misses; 0x2000 hits.
- Pulse flush while in FILL -> the fill completes and its response is delivered; the flush is applied in IDLE; the next request to the same line misses.
- Assert reset during FILL beat 3 and keep driving beats -> outputs return to reset values, the line is invalid, and the next request refetches it.
- WAYS = 1, NUMSETS = 4: pc 0x000 then 0x100 (same set) -> second request evicts the first; re-request of 0x000 misses.
